// File: rtl/dm_responder.sv
// dm_responder: data-memory responder sitting at the far end of the MEM-stage
// memory-control interface. It accepts one load or store per handshake, commits
// stores under a byte mask, and returns extended load data after LATENCY cycles.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready request handshake (ready only in IDLE)
//   addr                  byte address; word index = addr[WORD_ADDR_W+1:2]
//   byteen, wdata         store byte mask and lane-aligned store data
//   loadType              one-hot {lb, lbu, lh, lhu, lw}
//   rsp_valid             one-cycle response pulse
//   rdata, err            response payload, zero outside the response cycle
//   busy                  a request is outstanding
module dm_responder #(
  parameter int unsigned WORD_ADDR_W = 10,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  input  logic [4:0]  loadType,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << WORD_ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned AW    = WORD_ADDR_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [3:0]        byteen_q, byteen_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        ltype_q, ltype_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH];

  logic              be_ok_c, illegal_c, enter_resp_c, we_c;
  logic [31:0]       word_c, shifted_c, ld_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic              unused_addr_c;

  // Address bits above the memory are deliberately ignored (wrap-around).
  assign unused_addr_c = ^addr[31:AW];

  // Legality of the incoming request, evaluated only at the handshake.
  always_comb begin
    be_ok_c = 1'b0;
    case (byteen)
      4'b0000: be_ok_c = 1'b1;
      4'b0001: be_ok_c = (addr[1:0] == 2'd0);
      4'b0010: be_ok_c = (addr[1:0] == 2'd1);
      4'b0100: be_ok_c = (addr[1:0] == 2'd2);
      4'b1000: be_ok_c = (addr[1:0] == 2'd3);
      4'b0011: be_ok_c = (addr[1:0] == 2'd0);
      4'b1100: be_ok_c = (addr[1:0] == 2'd2);
      4'b1111: be_ok_c = (addr[1:0] == 2'd0);
      default: be_ok_c = 1'b0;
    endcase
    illegal_c = ((|byteen) && (|loadType))
             || ((loadType & (loadType - 5'd1)) != 5'd0)
             || !be_ok_c
             || ((loadType[2] || loadType[1]) && addr[0])
             || (loadType[0] && (addr[1:0] != 2'd0));
  end

  // State register and request latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      byteen_q  <= '0;
      wdata_q   <= '0;
      ltype_q   <= '0;
      illegal_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      byteen_q  <= byteen_d;
      wdata_q   <= wdata_d;
      ltype_q   <= ltype_d;
      illegal_q <= illegal_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic and request capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    byteen_d  = byteen_q;
    wdata_d   = wdata_q;
    ltype_d   = ltype_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d    = addr[AW-1:0];
          byteen_d  = byteen;
          wdata_d   = wdata;
          ltype_d   = loadType;
          illegal_d = illegal_c;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load extraction from the addressed word, using the values in effect at the
  // RESP-entering edge (the _d view also covers LATENCY == 1).
  always_comb begin
    word_c    = mem_q[addr_d[AW-1:2]];
    shifted_c = word_c >> {addr_d[1:0], 3'b000};
    byte_c    = shifted_c[7:0];
    half_c    = addr_d[1] ? word_c[31:16] : word_c[15:0];
    case (ltype_d)
      5'b10000: ld_c = {{24{byte_c[7]}}, byte_c};
      5'b01000: ld_c = {24'd0, byte_c};
      5'b00100: ld_c = {{16{half_c[15]}}, half_c};
      5'b00010: ld_c = {16'd0, half_c};
      5'b00001: ld_c = word_c;
      default:  ld_c = '0;
    endcase
  end

  // Response payload and memory write both happen on the edge entering RESP.
  always_comb begin
    enter_resp_c = (state_d == S_RESP) && (state_q != S_RESP);
    we_c         = enter_resp_c && !illegal_d && (|byteen_d);
    rdata_d      = (enter_resp_c && !illegal_d) ? ld_c : 32'd0;
    err_d        = enter_resp_c && illegal_d;
  end

  // Word array with per-lane write enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we_c) begin
      for (int l = 0; l < 4; l++) begin
        if (byteen_d[l]) mem_q[addr_d[AW-1:2]][8*l +: 8] <= wdata_d[8*l +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset, reset3;
  logic        rv2, rv3;
  logic [31:0] addr, wdata;
  logic [3:0]  byteen;
  logic [4:0]  loadType;
  logic        ready2, rsp2, err2, busy2;
  logic        ready3, rsp3, err3, busy3;
  logic [31:0] rdata2, rdata3;
  logic        sel;
  logic        o_ready, o_rsp, o_err, o_busy;
  logic [31:0] o_rdata;
  int          total = 0;
  int          bad   = 0;

  localparam logic [4:0] LB = 5'b10000, LBU = 5'b01000, LH = 5'b00100,
                         LHU = 5'b00010, LW = 5'b00001, NL = 5'b00000;

  always #5 clk = ~clk;

  dm_responder #(.WORD_ADDR_W(10), .LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(ready2),
    .addr(addr), .byteen(byteen), .wdata(wdata), .loadType(loadType),
    .rsp_valid(rsp2), .rdata(rdata2), .err(err2), .busy(busy2));

  dm_responder #(.WORD_ADDR_W(10), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset3), .req_valid(rv3), .req_ready(ready3),
    .addr(addr), .byteen(byteen), .wdata(wdata), .loadType(loadType),
    .rsp_valid(rsp3), .rdata(rdata3), .err(err3), .busy(busy3));

  assign o_ready = sel ? ready3 : ready2;
  assign o_rsp   = sel ? rsp3   : rsp2;
  assign o_err   = sel ? err3   : err2;
  assign o_busy  = sel ? busy3  : busy2;
  assign o_rdata = sel ? rdata3 : rdata2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the selected instance; checks latency, busy and payload.
  task automatic req(input logic s, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input logic [4:0] lt,
                     input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int lat;
    lat = s ? 3 : 2;
    sel = s;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(o_ready), 32'd1);
    addr = a; byteen = be; wdata = wd; loadType = lt;
    if (s) rv3 = 1'b1; else rv2 = 1'b1;
    @(posedge clk);
    #1;
    rv2 = 1'b0; rv3 = 1'b0;
    addr = $urandom(); byteen = 4'($urandom()); wdata = $urandom(); loadType = 5'($urandom());
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk({tag, ".rsp"}, 32'(o_rsp), 32'(c == lat));
      chk({tag, ".busy"}, 32'(o_busy), 32'd1);
      if (c == lat) begin
        chk({tag, ".err"}, 32'(o_err), 32'(exp_err));
        chk({tag, ".rdata"}, o_rdata, exp_rd);
      end
    end
    @(negedge clk);
    chk({tag, ".rsp_after"}, 32'(o_rsp), 32'd0);
    chk({tag, ".busy_after"}, 32'(o_busy), 32'd0);
    chk({tag, ".rdata_after"}, o_rdata, 32'd0);
  endtask

  initial begin
    reset = 1'b1; reset3 = 1'b1; rv2 = 1'b0; rv3 = 1'b0; sel = 1'b0;
    addr = '0; byteen = '0; wdata = '0; loadType = '0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(ready2), 32'd1);
    chk("rst.rsp", 32'(rsp2), 32'd0);
    chk("rst.busy", 32'(busy2), 32'd0);
    chk("rst.rdata", rdata2, 32'd0);
    chk("rst.err", 32'(err2), 32'd0);
    reset = 1'b0; reset3 = 1'b0;

    // Word store and load
    req(0, 32'h10, 4'b1111, 32'h8765_4321, NL, 0, 32'h0, "sw10");
    req(0, 32'h10, 4'b0000, 32'h0, LW, 0, 32'h8765_4321, "lw10");
    req(0, 32'h11, 4'b0000, 32'h0, LBU, 0, 32'h0000_0043, "lbu11");
    req(0, 32'h13, 4'b0000, 32'h0, LB, 0, 32'hFFFF_FF87, "lb13");
    req(0, 32'h1010, 4'b0000, 32'h0, LW, 0, 32'h8765_4321, "lw_wrap");

    // Byte lanes
    req(0, 32'h23, 4'b1000, 32'h9A00_0000, NL, 0, 32'h0, "sb23");
    req(0, 32'h23, 4'b0000, 32'h0, LB, 0, 32'hFFFF_FF9A, "lb23");
    req(0, 32'h23, 4'b0000, 32'h0, LBU, 0, 32'h0000_009A, "lbu23");
    req(0, 32'h20, 4'b0000, 32'h0, LW, 0, 32'h9A00_0000, "lw20");

    // Halfwords
    req(0, 32'h32, 4'b1100, 32'h7FFE_0000, NL, 0, 32'h0, "sh32a");
    req(0, 32'h32, 4'b0000, 32'h0, LH, 0, 32'h0000_7FFE, "lh32a");
    req(0, 32'h32, 4'b1100, 32'h8001_0000, NL, 0, 32'h0, "sh32b");
    req(0, 32'h32, 4'b0000, 32'h0, LHU, 0, 32'h0000_8001, "lhu32");
    req(0, 32'h32, 4'b0000, 32'h0, LH, 0, 32'hFFFF_8001, "lh32b");

    // Errors and no-op
    req(0, 32'h06, 4'b0000, 32'h0, LW, 1, 32'h0, "lw06_err");
    req(0, 32'h00, 4'b1111, 32'hAABB_CCDD, NL, 0, 32'h0, "sw00");
    req(0, 32'h01, 4'b0001, 32'h0000_00EE, NL, 1, 32'h0, "sb01_err");
    req(0, 32'h00, 4'b0000, 32'h0, LW, 0, 32'hAABB_CCDD, "lw00");
    req(0, 32'h21, 4'b0000, 32'h0, LH, 1, 32'h0, "lh21_err");
    req(0, 32'h10, 4'b1111, 32'h1111_1111, LW, 1, 32'h0, "st_ld_err");
    req(0, 32'h10, 4'b0000, 32'h0, 5'b00011, 1, 32'h0, "lt_multi_err");
    req(0, 32'h10, 4'b0000, 32'h0, LW, 0, 32'h8765_4321, "lw10_kept");
    req(0, 32'h10, 4'b0000, 32'h0, NL, 0, 32'h0, "noop");

    // req_valid held high: accepted only in IDLE, one response per handshake
    sel = 1'b0;
    @(negedge clk);
    addr = 32'h10; byteen = 4'b0000; wdata = 32'h0; loadType = LW; rv2 = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("hold.rsp%0d", i), 32'(rsp2), 32'(i == 1 || i == 4));
      chk($sformatf("hold.ready%0d", i), 32'(ready2), 32'(i == 2 || i >= 5));
      if (i == 1 || i == 4) chk($sformatf("hold.rdata%0d", i), rdata2, 32'h8765_4321);
      if (i == 4) rv2 = 1'b0;
    end

    // Reset while a LATENCY=3 store is in flight
    sel = 1'b1;
    @(negedge clk);
    addr = 32'h40; byteen = 4'b1111; wdata = 32'h1122_3344; loadType = NL; rv3 = 1'b1;
    @(posedge clk);
    #1 rv3 = 1'b0;
    @(negedge clk);
    chk("inflight.busy", 32'(busy3), 32'd1);
    reset3 = 1'b1;
    #1;
    chk("rst3.busy", 32'(busy3), 32'd0);
    chk("rst3.ready", 32'(ready3), 32'd1);
    chk("rst3.rsp", 32'(rsp3), 32'd0);
    @(negedge clk);
    reset3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst3.norsp%0d", i), 32'(rsp3), 32'd0);
      chk($sformatf("rst3.idle%0d", i), 32'(busy3), 32'd0);
    end
    req(1, 32'h40, 4'b0000, 32'h0, LW, 0, 32'h0, "lw40_l3");
    req(1, 32'h44, 4'b1111, 32'hCAFE_F00D, NL, 0, 32'h0, "sw44_l3");
    req(1, 32'h46, 4'b0000, 32'h0, LHU, 0, 32'h0000_CAFE, "lhu46_l3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
